// File: rtl/game_phase_sched.sv
// Purpose: frame sequencer for the typing game. It paces the fall tick, serialises the
//          FALL/SPAWN/KEY line-buffer phases and keeps the score, target, chance and level state.
// Latency: every output is registered. A req asserts one cycle after its trigger and drops one
//          cycle after phase_done is sampled. Counters update one cycle after each hit/miss pulse.
// Backpressure: a phase holds phase_req until the datapath returns phase_done. pause freezes only
//          the tick counter, so a phase that is already running still completes.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   pause           1 = run, 0 = freeze the fall tick
//   key_valid       a key matched a falling glyph; latched into key_pending
//   phase_done      the datapath finished the requested phase
//   spawned         qualifies phase_done in SPAWN (1 = a glyph was placed)
//   hit, miss       a glyph was resolved (hit = erased by key, miss = fell past the bottom)
//   phase_req       one-hot {KEY,SPAWN,FALL}; 0 while idle
//   score_bcd       three-digit BCD score
//   target_bcd      spawns still to come in this level, BCD
//   chance          remaining chances
//   level           0..4, where 4 is the boss level
//   boss_show       the boss level is active
//   boss_blink      HUD blink phase while the boss level is active
//   game_over       sticky until rst
//   key_pending     a key request is waiting for its KEY phase
module game_phase_sched #(
  parameter int TICK_DIV    = 2500000,
  parameter int SPAWN_EVERY = 32,
  parameter int BLINK_DIV   = 1250000,
  parameter int CHANCE_INIT = 9,
  parameter int L0_TGT      = 30,
  parameter int L1_TGT      = 60,
  parameter int L2_TGT      = 70,
  parameter int L3_TGT      = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pause,
  input  logic        key_valid,
  input  logic        phase_done,
  input  logic        spawned,
  input  logic        hit,
  input  logic        miss,
  output logic [2:0]  phase_req,
  output logic [11:0] score_bcd,
  output logic [11:0] target_bcd,
  output logic [3:0]  chance,
  output logic [2:0]  level,
  output logic        boss_show,
  output logic        boss_blink,
  output logic        game_over,
  output logic        key_pending
);

  function automatic logic [11:0] to_bcd(input int v);
    return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (r[3:0] != 4'd9) begin
      r[3:0] = r[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      if (r[7:4] != 4'd9) begin
        r[7:4] = r[7:4] + 4'd1;
      end else begin
        r[7:4] = 4'd0;
        // The hundreds digit wraps, so the score rolls over from 999 to 000.
        r[11:8] = (r[11:8] == 4'd9) ? 4'd0 : r[11:8] + 4'd1;
      end
    end
    return r;
  endfunction

  // The caller only uses this on non-zero values.
  function automatic logic [11:0] bcd_dec(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (r[3:0] != 4'd0) begin
      r[3:0] = r[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (r[7:4] != 4'd0) begin
        r[7:4] = r[7:4] - 4'd1;
      end else begin
        r[7:4]  = 4'd9;
        r[11:8] = r[11:8] - 4'd1;
      end
    end
    return r;
  endfunction

  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int SW = $clog2(SPAWN_EVERY + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SPAWN_LAST = SW'(SPAWN_EVERY - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [11:0]   TGT0_BCD   = to_bcd(L0_TGT);
  localparam logic [11:0]   TGT1_BCD   = to_bcd(L1_TGT);
  localparam logic [11:0]   TGT2_BCD   = to_bcd(L2_TGT);
  localparam logic [11:0]   TGT3_BCD   = to_bcd(L3_TGT);

  localparam logic [2:0] REQ_FALL  = 3'b001;
  localparam logic [2:0] REQ_SPAWN = 3'b010;
  localparam logic [2:0] REQ_KEY   = 3'b100;

  typedef enum logic [2:0] {S_WAIT, S_FALL, S_SPAWN, S_KEY, S_OVER} state_t;

  state_t        state;
  logic [TW-1:0] tick_cnt;
  logic [SW-1:0] spawn_cnt;
  logic [BW-1:0] blink_cnt;
  logic [9:0]    resolved;
  logic [9:0]    res_sum;
  logic [9:0]    cur_tgt;
  logic [11:0]   next_tgt_bcd;
  logic          alive;
  logic          lvl_up;
  logic          spawn_dec;

  // While chance is zero the game is about to end: phase handshakes are ignored
  // and the state machine moves to OVER on the next edge.
  assign alive   = (chance != 4'd0);
  assign res_sum = resolved + {9'd0, hit} + {9'd0, miss};

  always_comb begin
    cur_tgt      = 10'(L0_TGT);
    next_tgt_bcd = TGT1_BCD;
    case (level)
      3'd1: begin cur_tgt = 10'(L1_TGT); next_tgt_bcd = TGT2_BCD; end
      3'd2: begin cur_tgt = 10'(L2_TGT); next_tgt_bcd = TGT3_BCD; end
      3'd3: begin cur_tgt = 10'(L3_TGT); next_tgt_bcd = 12'h000;  end
      default: ;
    endcase
  end

  assign lvl_up    = (level != 3'd4) && (res_sum >= cur_tgt);
  assign spawn_dec = (state == S_SPAWN) && alive && phase_done && spawned &&
                     (target_bcd != 12'h000);

  // Phase sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_WAIT;
      phase_req   <= 3'b000;
      key_pending <= 1'b0;
      tick_cnt    <= '0;
      spawn_cnt   <= '0;
      game_over   <= 1'b0;
    end else if (state == S_OVER) begin
      phase_req <= 3'b000;
    end else if (!alive) begin
      state     <= S_OVER;
      phase_req <= 3'b000;
      game_over <= 1'b1;
    end else begin
      if (key_valid) key_pending <= 1'b1;
      case (state)
        S_WAIT: begin
          if (pause) begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt  <= '0;
              state     <= S_FALL;
              phase_req <= REQ_FALL;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        S_FALL: begin
          if (phase_done) begin
            if (spawn_cnt == SPAWN_LAST) begin
              spawn_cnt <= '0;
              state     <= S_SPAWN;
              phase_req <= REQ_SPAWN;
            end else begin
              spawn_cnt <= spawn_cnt + SW'(1);
              state     <= key_pending ? S_KEY : S_WAIT;
              phase_req <= key_pending ? REQ_KEY : 3'b000;
            end
          end
        end
        S_SPAWN: begin
          if (phase_done) begin
            state     <= key_pending ? S_KEY : S_WAIT;
            phase_req <= key_pending ? REQ_KEY : 3'b000;
          end
        end
        S_KEY: begin
          if (phase_done) begin
            // A key arriving on the completing edge belongs to the next KEY phase.
            key_pending <= key_valid;
            state       <= S_WAIT;
            phase_req   <= 3'b000;
          end
        end
        default: begin
          state     <= S_WAIT;
          phase_req <= 3'b000;
        end
      endcase
    end
  end

  // Game bookkeeping and the boss blink divider.
  always_ff @(posedge clk) begin
    if (rst) begin
      score_bcd  <= 12'h000;
      target_bcd <= TGT0_BCD;
      chance     <= 4'(CHANCE_INIT);
      level      <= 3'd0;
      resolved   <= '0;
      boss_show  <= 1'b0;
      boss_blink <= 1'b0;
      blink_cnt  <= '0;
    end else begin
      if (!game_over) begin
        if (hit) score_bcd <= bcd_inc(score_bcd);
        if (miss && alive) chance <= chance - 4'd1;
        if (lvl_up) begin
          // A level-up reloads the target and wins over a spawn decrement on the same edge.
          level      <= level + 3'd1;
          resolved   <= '0;
          target_bcd <= next_tgt_bcd;
          boss_show  <= (level == 3'd3);
        end else begin
          if (level != 3'd4) resolved <= res_sum;
          if (spawn_dec) target_bcd <= bcd_dec(target_bcd);
        end
      end
      if (level == 3'd4) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt  <= '0;
          boss_blink <= ~boss_blink;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end else begin
        blink_cnt  <= '0;
        boss_blink <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_game_phase_sched.sv
module tb_game_phase_sched;

  localparam int TICK_DIV    = 4;
  localparam int SPAWN_EVERY = 2;
  localparam int BLINK_DIV   = 5;
  localparam int CHANCE_INIT = 9;
  localparam int L0_TGT = 30, L1_TGT = 60, L2_TGT = 70, L3_TGT = 100;

  localparam int PH_IDLE = 0, PH_FALL = 1, PH_SPAWN = 2, PH_KEY = 3, PH_OVER = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pause = 1'b0;
  logic key_valid = 1'b0;
  logic spawned = 1'b1;
  logic hit = 1'b0;
  logic miss = 1'b0;
  logic auto_en = 1'b1;
  logic auto_done = 1'b0;
  logic man_done = 1'b0;
  logic phase_done;

  logic [2:0]  phase_req;
  logic [11:0] score_bcd;
  logic [11:0] target_bcd;
  logic [3:0]  chance;
  logic [2:0]  level;
  logic        boss_show;
  logic        boss_blink;
  logic        game_over;
  logic        key_pending;

  int n_chk = 0;
  int n_pass = 0;
  bit cmp_on = 1'b0;

  assign phase_done = auto_en ? auto_done : man_done;

  game_phase_sched #(
    .TICK_DIV(TICK_DIV), .SPAWN_EVERY(SPAWN_EVERY), .BLINK_DIV(BLINK_DIV),
    .CHANCE_INIT(CHANCE_INIT), .L0_TGT(L0_TGT), .L1_TGT(L1_TGT),
    .L2_TGT(L2_TGT), .L3_TGT(L3_TGT)
  ) dut (
    .clk(clk), .rst(rst), .pause(pause), .key_valid(key_valid),
    .phase_done(phase_done), .spawned(spawned), .hit(hit), .miss(miss),
    .phase_req(phase_req), .score_bcd(score_bcd), .target_bcd(target_bcd),
    .chance(chance), .level(level), .boss_show(boss_show), .boss_blink(boss_blink),
    .game_over(game_over), .key_pending(key_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input logic [2:0] v, input string name);
    int n = 0;
    while (phase_req !== v && n < 100) begin
      tick();
      n++;
    end
    chk(name, 32'(phase_req), 32'(v));
  endtask

  // Datapath stand-in: answers each request with phase_done two cycles after it appears.
  int age = 0;
  always @(posedge clk) begin
    #1;
    if (auto_done) begin
      auto_done = 1'b0;
      age = 0;
    end else if (phase_req != 3'b000) begin
      age++;
      if (age >= 2) auto_done = 1'b1;
    end else begin
      age = 0;
    end
  end

  // Reference model: game state as plain integers, phases as a current-activity number.
  int tgt_tab [5] = '{L0_TGT, L1_TGT, L2_TGT, L3_TGT, 0};
  int m_ph, m_tick, m_falls, m_score, m_target, m_chance, m_level, m_res, m_boss_cyc;
  bit m_pend;
  int o_ph, o_chance, o_level;
  bit o_pend, sp_dec;

  function automatic logic [31:0] bcd(input int v);
    return 32'(((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10));
  endfunction

  function automatic logic [31:0] req_of(input int ph);
    case (ph)
      PH_FALL:  return 32'd1;
      PH_SPAWN: return 32'd2;
      PH_KEY:   return 32'd4;
      default:  return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ph = PH_IDLE; m_tick = 0; m_falls = 0; m_pend = 1'b0;
      m_score = 0; m_target = tgt_tab[0]; m_chance = CHANCE_INIT;
      m_level = 0; m_res = 0; m_boss_cyc = 0;
    end else begin
      o_ph = m_ph; o_chance = m_chance; o_pend = m_pend; o_level = m_level;
      sp_dec = (o_ph == PH_SPAWN) && phase_done && spawned && (o_chance != 0) && (m_target > 0);
      if (o_level == 4) m_boss_cyc++;
      else m_boss_cyc = 0;
      if (o_ph != PH_OVER) begin
        if (hit) m_score = (m_score + 1) % 1000;
        if (miss && m_chance > 0) m_chance--;
        if (o_level < 4) begin
          m_res += int'(hit) + int'(miss);
          if (m_res >= tgt_tab[o_level]) begin
            m_level = o_level + 1;
            m_res = 0;
            m_target = tgt_tab[m_level];
          end else if (sp_dec) begin
            m_target--;
          end
        end else if (sp_dec) begin
          m_target--;
        end
      end
      if (o_ph == PH_OVER) begin
        m_ph = PH_OVER;
      end else if (o_chance == 0) begin
        m_ph = PH_OVER;
      end else begin
        if (key_valid) m_pend = 1'b1;
        case (o_ph)
          PH_IDLE: if (pause) begin
            if (m_tick == TICK_DIV - 1) begin m_tick = 0; m_ph = PH_FALL; end
            else m_tick++;
          end
          PH_FALL: if (phase_done) begin
            m_falls++;
            if (m_falls % SPAWN_EVERY == 0) m_ph = PH_SPAWN;
            else m_ph = o_pend ? PH_KEY : PH_IDLE;
          end
          PH_SPAWN: if (phase_done) m_ph = o_pend ? PH_KEY : PH_IDLE;
          PH_KEY: if (phase_done) begin m_pend = key_valid; m_ph = PH_IDLE; end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("m_phase_req", 32'(phase_req), req_of(m_ph));
      chk("m_score", 32'(score_bcd), bcd(m_score));
      chk("m_target", 32'(target_bcd), bcd(m_target));
      chk("m_chance", 32'(chance), 32'(m_chance));
      chk("m_level", 32'(level), 32'(m_level));
      chk("m_boss_show", 32'(boss_show), 32'(m_level == 4));
      chk("m_boss_blink", 32'(boss_blink), (m_level == 4) ? 32'((m_boss_cyc / BLINK_DIV) % 2) : 32'd0);
      chk("m_game_over", 32'(game_over), 32'(m_ph == PH_OVER));
      chk("m_key_pending", 32'(key_pending), 32'(m_pend));
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_req"}, 32'(phase_req), 32'h0);
    chk({tag, "_score"}, 32'(score_bcd), 32'h000);
    chk({tag, "_target"}, 32'(target_bcd), 32'h030);
    chk({tag, "_chance"}, 32'(chance), 32'd9);
    chk({tag, "_level"}, 32'(level), 32'd0);
    chk({tag, "_boss"}, {30'd0, boss_show, boss_blink}, 32'd0);
    chk({tag, "_over"}, 32'(game_over), 32'd0);
    chk({tag, "_pending"}, 32'(key_pending), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int v;
    logic [2:0] prev;
    logic [2:0] seq[$];
    logic pb;

    // Reset state.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_reset("rst0");
    cmp_on = 1'b1;

    // Free-running phase pacing: FALL, FALL+SPAWN, repeating.
    pause = 1'b1;
    n = 0;
    while (phase_req !== 3'b001 && n < 20) begin tick(); n++; end
    chk("first_fall_latency", n, 4);
    seq.delete();
    seq.push_back(phase_req);
    prev = phase_req;
    n = 0;
    while (seq.size() < 6 && n < 100) begin
      tick();
      n++;
      if (phase_req != prev && phase_req != 3'b000) seq.push_back(phase_req);
      prev = phase_req;
    end
    v = 0;
    foreach (seq[i]) v = v * 8 + int'(seq[i]);
    chk("phase_order", v, 'o112112);
    chk("target_after_spawn", 32'(target_bcd), 32'h029);
    spawned = 1'b0;
    wait_req(3'b000, "spawn_done_nofit");
    chk("target_no_slot", 32'(target_bcd), 32'h029);
    spawned = 1'b1;

    // pause freezes the tick for exactly its duration.
    do_reset();
    tick();
    n = 1;
    pause = 1'b0;
    repeat (10) begin tick(); n++; end
    pause = 1'b1;
    while (phase_req !== 3'b001 && n < 40) begin tick(); n++; end
    chk("paused_fall_latency", n, 14);
    pause = 1'b0;
    n = 0;
    while (phase_req !== 3'b000 && n < 10) begin tick(); n++; end
    chk("fall_completes_paused", n, 2);
    repeat (10) tick();
    chk("no_fall_while_paused", 32'(phase_req), 32'h0);
    pause = 1'b1;

    // Two keys ahead of a spawn-tick FALL yield FALL -> SPAWN -> one KEY.
    do_reset();
    wait_req(3'b001, "k_fall1");
    wait_req(3'b000, "k_fall1_done");
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    chk("key_latched", 32'(key_pending), 32'd1);
    wait_req(3'b001, "k_fall2");
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    pause = 1'b0;
    seq.delete();
    prev = phase_req;
    repeat (30) begin
      tick();
      if (phase_req != prev && phase_req != 3'b000) seq.push_back(phase_req);
      prev = phase_req;
    end
    v = 0;
    foreach (seq[i]) v = v * 8 + int'(seq[i]);
    chk("key_order", v, 'o24);
    chk("key_cleared", 32'(key_pending), 32'd0);

    // Hits: level progression, BCD score and wrap, boss blink.
    do_reset();
    hit = 1'b1;
    repeat (30) tick();
    hit = 1'b0;
    chk("score_30", 32'(score_bcd), 32'h030);
    chk("level_1", 32'(level), 32'd1);
    chk("target_l1", 32'(target_bcd), 32'h060);
    hit = 1'b1;
    repeat (969) tick();
    hit = 1'b0;
    chk("score_999", 32'(score_bcd), 32'h999);
    chk("level_4", 32'(level), 32'd4);
    chk("boss_show", 32'(boss_show), 32'd1);
    chk("target_l4", 32'(target_bcd), 32'h000);
    hit = 1'b1;
    tick();
    hit = 1'b0;
    chk("score_wrap", 32'(score_bcd), 32'h000);
    pb = boss_blink;
    n = 0;
    while (boss_blink === pb && n < 20) begin tick(); n++; end
    pb = boss_blink;
    n = 0;
    while (boss_blink === pb && n < 20) begin tick(); n++; end
    chk("blink_period", n, BLINK_DIV);
    do_reset();
    check_reset("rst1");

    // Last chance lost mid-phase: game over, req drops, later inputs ignored.
    pause = 1'b1;
    auto_en = 1'b0;
    wait_req(3'b001, "go_fall");
    miss = 1'b1;
    repeat (8) tick();
    miss = 1'b0;
    chk("chance_1", 32'(chance), 32'd1);
    hit = 1'b1;
    miss = 1'b1;
    tick();
    hit = 1'b0;
    miss = 1'b0;
    chk("go_score", 32'(score_bcd), 32'h001);
    chk("go_chance", 32'(chance), 32'd0);
    chk("go_not_yet", 32'(game_over), 32'd0);
    tick();
    chk("go_set", 32'(game_over), 32'd1);
    chk("go_req_drop", 32'(phase_req), 32'h0);
    key_valid = 1'b1;
    man_done = 1'b1;
    tick();
    key_valid = 1'b0;
    man_done = 1'b0;
    tick();
    chk("go_key_ignored", 32'(key_pending), 32'd0);
    repeat (20) tick();
    chk("go_req_idle", 32'(phase_req), 32'h0);

    // Stray phase_done while idle, then reset in the middle of a phase.
    do_reset();
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    chk("idle_done_ignored", 32'(phase_req), 32'h0);
    wait_req(3'b001, "rm_fall");
    man_done = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    man_done = 1'b0;
    chk("rst_mid_phase", 32'(phase_req), 32'h0);
    auto_en = 1'b1;
    wait_req(3'b001, "rm_fall2");
    n = 0;
    while (phase_req === 3'b001 && n < 10) begin tick(); n++; end
    chk("rst_no_spawn_cnt", 32'(phase_req), 32'h0);
    repeat (5) tick();

    cmp_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
